// File: rtl/ex_pipe_ctrl.sv
// Execution-stage sequencing controller: tracks EX/WB destination slots and drives
// operand forwarding, load-use stalls, branch flushes and data-memory wait holds.
module ex_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_opcode,
    input  logic [3:0]       id_ra,
    input  logic [3:0]       id_rb,
    input  logic             id_uses_rb,
    input  logic [3:0]       id_dest,
    input  logic             br_taken,
    input  logic [4:0]       br_target,
    input  logic             mem_busy,
    output logic             stall_fetch,
    output logic             stall_read,
    output logic             ex_bubble,
    output logic             flush_read,
    output logic             pc_load,
    output logic [4:0]       pc_load_val,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    // Opcode map shared with the rest of the core: ALU writers occupy NOP+1..ARSH.
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ARSH = 5'd9;
    localparam logic [4:0] OP_LDW  = 5'd10;
    localparam logic [4:0] OP_STR  = 5'd11;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH1  = 2'b01,
        FLUSH2  = 2'b10,
        MEMWAIT = 2'b11
    } state_t;

    state_t           state_reg;
    logic             pc_load_reg;
    logic [4:0]       pc_load_val_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic       ex_valid_reg;
    logic [3:0] ex_dest_reg;
    logic       ex_load_reg;
    logic       ex_mem_reg;
    logic       wb_valid_reg;
    logic [3:0] wb_dest_reg;

    logic id_writer;
    logic id_is_load;
    logic id_is_mem;
    logic hazard;
    logic mem_wait_req;
    logic issue;

    assign id_writer  = ((id_opcode > OP_NOP) && (id_opcode <= OP_ARSH)) || (id_opcode == OP_LDW);
    assign id_is_load = (id_opcode == OP_LDW);
    assign id_is_mem  = (id_opcode == OP_LDW) || (id_opcode == OP_STR);

    assign hazard = id_valid & ex_valid_reg & ex_load_reg &
                    ((ex_dest_reg == id_ra) | (id_uses_rb & (ex_dest_reg == id_rb)));
    assign mem_wait_req = mem_busy & ex_mem_reg;

    always_comb begin
        stall_fetch = 1'b0;
        stall_read  = 1'b0;
        ex_bubble   = 1'b0;
        flush_read  = 1'b0;
        case (state_reg)
            RUN: begin
                // A branch or a memory wait starting this cycle outranks the load-use stall.
                stall_fetch = hazard & ~br_taken & ~mem_wait_req;
                stall_read  = hazard & ~br_taken & ~mem_wait_req;
                ex_bubble   = hazard & ~br_taken & ~mem_wait_req;
            end
            FLUSH1, FLUSH2: begin
                flush_read = 1'b1;
                ex_bubble  = 1'b1;
            end
            MEMWAIT: begin
                stall_fetch = 1'b1;
                stall_read  = 1'b1;
            end
            default: ;
        endcase
    end

    assign issue = id_valid & ~stall_read & ~ex_bubble;

    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (ex_valid_reg && !ex_load_reg && (ex_dest_reg == src))
            return 2'b01;
        else if (wb_valid_reg && (wb_dest_reg == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(id_ra);
    assign fwd_b = id_uses_rb ? fwd_sel(id_rb) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_load_reg     <= 1'b0;
            pc_load_val_reg <= 5'd0;
            stall_cnt_reg   <= '0;
            ex_valid_reg    <= 1'b0;
            ex_dest_reg     <= 4'd0;
            ex_load_reg     <= 1'b0;
            ex_mem_reg      <= 1'b0;
            wb_valid_reg    <= 1'b0;
            wb_dest_reg     <= 4'd0;
        end else begin
            if (stall_read && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            pc_load_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (br_taken) begin
                        state_reg       <= FLUSH1;
                        pc_load_reg     <= 1'b1;
                        pc_load_val_reg <= br_target;
                    end else if (mem_wait_req) begin
                        state_reg <= MEMWAIT;
                    end
                end
                FLUSH1:  state_reg <= FLUSH2;
                FLUSH2:  state_reg <= RUN;
                MEMWAIT: if (!mem_busy) state_reg <= RUN;
                default: state_reg <= RUN;
            endcase

            // Slots freeze for the whole memory wait; flush cycles never issue, so EX empties.
            if (state_reg != MEMWAIT) begin
                wb_valid_reg <= ex_valid_reg;
                wb_dest_reg  <= ex_dest_reg;
                if (issue) begin
                    ex_valid_reg <= id_writer;
                    ex_dest_reg  <= id_dest;
                    ex_load_reg  <= id_is_load;
                    ex_mem_reg   <= id_is_mem;
                end else begin
                    ex_valid_reg <= 1'b0;
                    ex_dest_reg  <= 4'd0;
                    ex_load_reg  <= 1'b0;
                    ex_mem_reg   <= 1'b0;
                end
            end
        end
    end

    assign state       = state_reg;
    assign pc_load     = pc_load_reg;
    assign pc_load_val = pc_load_val_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule
